// File: rtl/rf_wr_arbiter.sv
// Register-file write arbiter: four requesters share one write port, one write per two cycles.
// Define ARB_ROUND_ROBIN_EN for rotating priority; the default build uses fixed priority (req[0] highest).
module rf_wr_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [11:0]  wr_addr,
  input  logic [127:0] wr_data,
  output logic [3:0]   ack,
  output logic [7:0]   rf_en,
  output logic [31:0]  rf_d_in,
  output logic         busy,
  output logic [7:0]   wr_count
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state;
  logic [3:0]  ack_p1;
  logic [7:0]  en_p1;
  logic [31:0] data_p1;
  logic [1:0]  winner;
  logic [2:0]  win_addr;
  logic [31:0] win_data;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] decode(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr;

  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign winner = pick_rr(req, ptr);
`else
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else if (r[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign winner = pick_fixed(req);
`endif

  always_comb begin
    win_addr = wr_addr[2:0];
    win_data = wr_data[31:0];
    case (winner)
      2'd1: begin win_addr = wr_addr[5:3];  win_data = wr_data[63:32];  end
      2'd2: begin win_addr = wr_addr[8:6];  win_data = wr_data[95:64];  end
      2'd3: begin win_addr = wr_addr[11:9]; win_data = wr_data[127:96]; end
      default: ;
    endcase
  end

  // p0 -> p1: arbitrate in IDLE, present the registered write for one WRITE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ack_p1   <= '0;
      en_p1    <= '0;
      data_p1  <= '0;
      busy     <= 1'b0;
      wr_count <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= WRITE;
            busy    <= 1'b1;
            ack_p1  <= 4'b0001 << winner;
            en_p1   <= decode(win_addr);
            data_p1 <= win_data;
`ifdef ARB_ROUND_ROBIN_EN
            ptr     <= winner + 2'd1;
`endif
          end
        end
        WRITE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ack_p1   <= '0;
          en_p1    <= '0;
          data_p1  <= '0;
          wr_count <= sat_inc(wr_count);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset in the WRITE cycle kills the write before the register file can capture it
  assign ack     = ack_p1 & {4{~reset}};
  assign rf_en   = en_p1 & {8{~reset}};
  assign rf_d_in = data_p1;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter; expectations follow the active arbitration build.
module tb_rf_wr_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [11:0]  wr_addr;
  logic [127:0] wr_data;
  logic [3:0]   ack;
  logic [7:0]   rf_en;
  logic [31:0]  rf_d_in;
  logic         busy;
  logic [7:0]   wr_count;

  int checks = 0;
  int errors = 0;

  rf_wr_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ack      (ack),
    .rf_en    (rf_en),
    .rf_d_in  (rf_d_in),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [31:0] d);
    wr_addr[3*i +: 3]  = a;
    wr_data[32*i +: 32] = d;
  endtask

  // One edge into WRITE, then check the presented write
  task automatic expect_write(input string tag, input logic [3:0] ea, input logic [7:0] ee,
                              input logic [31:0] ed);
    tick();
    chk({tag, "_ack"}, 32'(ack), 32'(ea));
    chk({tag, "_en"}, 32'(rf_en), 32'(ee));
    chk({tag, "_data"}, rf_d_in, ed);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_onehot"}, 32'($countones(rf_en)), 32'd1);
  endtask

  task automatic expect_idle(input string tag, input logic [7:0] ecnt);
    tick();
    chk({tag, "_ack0"}, 32'(ack), 32'd0);
    chk({tag, "_en0"}, 32'(rf_en), 32'd0);
    chk({tag, "_busy0"}, 32'(busy), 32'd0);
    chk({tag, "_cnt"}, 32'(wr_count), 32'(ecnt));
  endtask

  initial begin
    logic [3:0] second_ack;
    logic [7:0] exp_cnt;
    reset   = 1'b1;
    req     = '0;
    wr_addr = '0;
    wr_data = '0;

    // Reset state
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_en", 32'(rf_en), 32'd0);
    chk("rst_data", rf_d_in, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(wr_count), 32'd0);
    reset = 1'b0;

    // Idle with no request stays idle
    expect_idle("noreq", 8'd0);

    // Single write
    set_req(0, 3'd5, 32'hDEADBEEF);
    req = 4'b0001;
    expect_write("single", 4'b0001, 8'h20, 32'hDEADBEEF);
    req = 4'b0000;
    expect_idle("single_end", 8'd1);
    chk("single_data_clr", rf_d_in, 32'd0);

    // Two requesters on register 4, serialised
    set_req(1, 3'd4, 32'h11);
    set_req(3, 3'd4, 32'h33);
    req = 4'b1010;
    expect_write("same1", 4'b0010, 8'h10, 32'h11);
    req = 4'b1000;
    expect_idle("same1_end", 8'd2);
    expect_write("same2", 4'b1000, 8'h10, 32'h33);
    req = 4'b0000;
    expect_idle("same2_end", 8'd3);

    // All four, each dropping req after its ack
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 32'(i + 1));
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      expect_write($sformatf("all%0d", i), 4'b0001 << i, 8'b1 << i, 32'(i + 1));
      req[i] = 1'b0;
      expect_idle($sformatf("all%0d_end", i), 8'(4 + i));
    end

    // All four held: fixed priority re-grants requester 0, rotation moves on
`ifdef ARB_ROUND_ROBIN_EN
    second_ack = 4'b0010;
`else
    second_ack = 4'b0001;
`endif
    req = 4'b1111;
    expect_write("hold1", 4'b0001, 8'h01, 32'd1);
    expect_idle("hold1_end", 8'd8);
    expect_write("hold2", second_ack, (second_ack == 4'b0001) ? 8'h01 : 8'h02,
                 (second_ack == 4'b0001) ? 32'd1 : 32'd2);
    req = 4'b0000;
    expect_idle("hold2_end", 8'd9);

    // Reset during requester 2's WRITE cycle aborts it
    set_req(2, 3'd3, 32'hCAFE0002);
    req = 4'b0100;
    expect_write("pre_abort", 4'b0100, 8'h08, 32'hCAFE0002);
    reset = 1'b1;
    #1;
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_en", 32'(rf_en), 32'd0);
    tick();
    chk("abort_ack_next", 32'(ack), 32'd0);
    chk("abort_en_next", 32'(rf_en), 32'd0);
    chk("abort_data_next", rf_d_in, 32'd0);
    chk("abort_busy_next", 32'(busy), 32'd0);
    chk("abort_cnt_next", 32'(wr_count), 32'd0);
    reset = 1'b0;
    // Held request survives the reset and is granted again
    expect_write("regrant", 4'b0100, 8'h08, 32'hCAFE0002);
    expect_idle("regrant_end", 8'd1);

    // Back-to-back writes saturate the counter (req held continuously)
    set_req(0, 3'd7, 32'h0000_0A5A);
    req = 4'b0001;
    exp_cnt = 8'd1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      checks++;
      assert (ack === 4'b0001 && rf_en === 8'h80) else begin
        errors++;
        $error("FAIL sat_write%0d: observed ack %0h en %0h expected ack 1 en 80", i, ack, rf_en);
      end
      tick();
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      checks++;
      assert (wr_count === exp_cnt) else begin
        errors++;
        $error("FAIL sat_cnt%0d: observed %0h expected %0h", i, wr_count, exp_cnt);
      end
    end
    req = 4'b0000;
    expect_idle("sat_final", 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
